phase_unwrapper: RTL and testbench

- Inverse of the phase-accumulate-and-wrap path.
- Takes a stream of wrapped, unsigned WIDTH-bit phase samples (modulus 2^WIDTH).
- Recovers the per-sample phase increment, tracks the number of wraps in a saturating signed counter, and outputs an extended-width unwrapped phase.
- Sits after the demodulator/phase wrapper, feeding logging and feedback paths that need continuous phase.

---
 rtl/phase_unwrapper_pkg.sv | 22 ++
 rtl/phase_wrap_counter.sv | 47 ++++
 rtl/phase_unwrapper.sv | 154 +++++++++++++++
 tb/tb_phase_unwrapper.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_unwrapper_pkg.sv
// Shared constants and types for the phase wrap/unwrap datapath.
// PHASE_W/PHASE_EXT must stay in step with the phase wrapper that feeds this block.
package phase_unwrapper_pkg;

    localparam int PHASE_W   = 14;
    localparam int PHASE_EXT = 8;
    localparam int PHASE_M   = 2 ** PHASE_W;
    localparam int PHASE_H   = 2 ** (PHASE_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        PRIMED = 1'b1
    } state_t;

    // Two's-complement step applied to the wrap counter.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b11
    } dir_t;

endpackage

// File: rtl/phase_wrap_counter.sv
// Saturating signed up/down wrap counter with a sticky overflow flag.
// A step that would leave the signed EXT-bit range is dropped and flags ovf instead.
module phase_wrap_counter
    import phase_unwrapper_pkg::*;
#(
    parameter int EXT = PHASE_EXT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic                  clear,
    input  logic [1:0]            dir,
    output logic signed [EXT-1:0] count,
    output logic                  ovf
);

    // Returns {hit, next}: hit means the step overflowed and next is the held value.
    function automatic logic [EXT:0] step_sat(input logic signed [EXT-1:0] cur,
                                              input logic [1:0]            step);
        logic signed [EXT:0] sum;
        sum = {cur[EXT-1], cur} + {{(EXT-1){step[1]}}, step};
        if (sum[EXT] != sum[EXT-1]) begin
            return {1'b1, cur};
        end
        return {1'b0, sum[EXT-1:0]};
    endfunction

    logic [EXT:0] step_r;

    assign step_r = step_sat(count, dir);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            count <= step_r[EXT-1:0];
            if (step_r[EXT]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_unwrapper.sv
// Recovers continuous phase from wrapped WIDTH-bit samples: per-sample increment,
// signed wrap count and {wraps, sample} unwrapped phase, two register stages deep.
module phase_unwrapper
    import phase_unwrapper_pkg::*;
#(
    parameter int WIDTH = PHASE_W,
    parameter int EXT   = PHASE_EXT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic        [WIDTH-1:0]     data_i,
    input  logic                        valid_i,
    input  logic                        clear_i,
    output logic signed [WIDTH+EXT-1:0] phase_o,
    output logic signed [WIDTH:0]       diff_o,
    output logic signed [EXT-1:0]       wraps_o,
    output logic                        valid_o,
    output logic                        ovf_o
);

    localparam logic signed [WIDTH:0] HALF_POS = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0] HALF_NEG = {2'b11, {(WIDTH-1){1'b0}}};

    // d = +H is treated as a down-wrap; d = -H is left alone.
    function automatic dir_t wrap_dir(input logic signed [WIDTH:0] d);
        if (d >= HALF_POS) begin
            return DIR_DOWN;
        end
        if (d < HALF_NEG) begin
            return DIR_UP;
        end
        return DIR_NONE;
    endfunction

    // Adding or subtracting M in WIDTH+1 bits is the same as flipping the top bit.
    function automatic logic signed [WIDTH:0] fold_diff(input logic signed [WIDTH:0] d);
        if (d >= HALF_POS || d < HALF_NEG) begin
            return {~d[WIDTH], d[WIDTH-1:0]};
        end
        return d;
    endfunction

    state_t                    state;
    state_t                    state_nx;
    logic        [WIDTH-1:0]   prev;
    logic                      accept;
    logic signed [WIDTH:0]     raw_d;

    logic                      vld_p1;
    logic                      first_p1;
    logic        [WIDTH-1:0]   sample_p1;
    logic signed [WIDTH:0]     d_p1;

    dir_t                      dir_p1;
    logic signed [WIDTH:0]     diff_c;

    logic                      vld_p2;
    logic        [WIDTH-1:0]   sample_p2;
    logic signed [WIDTH:0]     diff_p2;
    logic signed [EXT-1:0]     wraps;
    logic                      ovf;

    assign accept = valid_i & ~clear_i;
    assign raw_d  = $signed({1'b0, data_i}) - $signed({1'b0, prev});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clear_i) begin
            state_nx = IDLE;
        end else if (valid_i && state == IDLE) begin
            state_nx = PRIMED;
        end
    end

    // Stage 1: capture sample and raw difference against the previous sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            sample_p1 <= '0;
            d_p1      <= '0;
            prev      <= '0;
        end else if (clear_i) begin
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            sample_p1 <= '0;
            d_p1      <= '0;
            prev      <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                sample_p1 <= data_i;
                prev      <= data_i;
                first_p1  <= (state == IDLE);
                d_p1      <= (state == IDLE) ? '0 : raw_d;
            end
        end
    end

    always_comb begin
        diff_c = '0;
        dir_p1 = DIR_NONE;
        if (!first_p1) begin
            diff_c = fold_diff(d_p1);
            dir_p1 = wrap_dir(d_p1);
        end
    end

    // Stage 2: corrected increment and wrap count, presented at the outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2    <= 1'b0;
            sample_p2 <= '0;
            diff_p2   <= '0;
        end else if (clear_i) begin
            vld_p2    <= 1'b0;
            sample_p2 <= '0;
            diff_p2   <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sample_p2 <= sample_p1;
                diff_p2   <= diff_c;
            end
        end
    end

    phase_wrap_counter #(
        .EXT (EXT)
    ) u_wrap_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (vld_p1 & ~clear_i),
        .clear (clear_i),
        .dir   (dir_p1),
        .count (wraps),
        .ovf   (ovf)
    );

    assign phase_o = {wraps, sample_p2};
    assign diff_o  = diff_p2;
    assign wraps_o = wraps;
    assign valid_o = vld_p2;
    assign ovf_o   = ovf;

endmodule

// File: tb/tb_phase_unwrapper.sv
// Bench for phase_unwrapper: a default-width and a 2-bit-counter instance share stimulus
// and are compared every cycle against a modular-arithmetic model of unwrapping.
module tb_phase_unwrapper;
    import phase_unwrapper_pkg::*;

    localparam int W     = PHASE_W;
    localparam int M     = PHASE_M;
    localparam int H     = PHASE_H;
    localparam int EXT_A = 8;
    localparam int EXT_B = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          valid;
    logic                          clear;
    logic        [W-1:0]           data;

    logic signed [W+EXT_A-1:0]     phase_a;
    logic signed [W:0]             diff_a;
    logic signed [EXT_A-1:0]       wraps_a;
    logic                          valid_a;
    logic                          ovf_a;

    logic signed [W+EXT_B-1:0]     phase_b;
    logic signed [W:0]             diff_b;
    logic signed [EXT_B-1:0]       wraps_b;
    logic                          valid_b;
    logic                          ovf_b;

    always #5 clk = ~clk;

    phase_unwrapper #(.WIDTH(W), .EXT(EXT_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
        .phase_o(phase_a), .diff_o(diff_a), .wraps_o(wraps_a), .valid_o(valid_a), .ovf_o(ovf_a)
    );

    phase_unwrapper #(.WIDTH(W), .EXT(EXT_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
        .phase_o(phase_b), .diff_o(diff_b), .wraps_o(wraps_b), .valid_o(valid_b), .ovf_o(ovf_b)
    );

    typedef struct {
        bit vld;
        int phase;
        int diff;
        int wraps;
        bit ovf;
    } out_t;

    typedef struct {
        bit v;
        int d;
        bit c;
        bit e_vld;
        int e_phase;
        int e_diff;
        int e_wraps;
    } vec_t;

    out_t p1_m   [2];
    out_t disp_m [2];
    int   wraps_m[2];
    bit   ovf_m  [2];
    bit   primed_m[2];
    int   prev_m [2];

    int n_vec = 0;
    int n_bad = 0;

    // Reference: increment is the representative of (cur - prev) mod M in [-H, H);
    // each wrap is the multiple of M removed, i.e. (diff - delta) / M.
    task automatic model_edge(input bit v, input int d, input bit c, input bit r);
        int delta;
        int df;
        int dir;
        int nw;
        int lim;
        for (int i = 0; i < 2; i++) begin
            if (r || c) begin
                primed_m[i] = 1'b0;
                prev_m[i]   = 0;
                wraps_m[i]  = 0;
                ovf_m[i]    = 1'b0;
                p1_m[i]     = '{1'b0, 0, 0, 0, 1'b0};
                disp_m[i]   = '{1'b0, 0, 0, 0, 1'b0};
            end else begin
                if (p1_m[i].vld) disp_m[i] = p1_m[i];
                else             disp_m[i].vld = 1'b0;
                p1_m[i].vld = 1'b0;
                if (v) begin
                    delta = 0;
                    df    = 0;
                    dir   = 0;
                    if (primed_m[i]) begin
                        delta = d - prev_m[i];
                        df    = ((delta + H + M) % M) - H;
                        dir   = (df - delta) / M;
                    end
                    primed_m[i] = 1'b1;
                    lim = 1 << ((i == 0 ? EXT_A : EXT_B) - 1);
                    nw  = wraps_m[i] + dir;
                    if (nw >= lim || nw < -lim) ovf_m[i] = 1'b1;
                    else                        wraps_m[i] = nw;
                    prev_m[i] = d;
                    p1_m[i]   = '{1'b1, wraps_m[i] * M + d, df, wraps_m[i], ovf_m[i]};
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        out_t act;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) act = '{valid_a, int'(phase_a), int'(diff_a), int'(wraps_a), ovf_a};
            else        act = '{valid_b, int'(phase_b), int'(diff_b), int'(wraps_b), ovf_b};
            n_vec++;
            if (act.vld != disp_m[i].vld || act.phase != disp_m[i].phase ||
                act.diff != disp_m[i].diff || act.wraps != disp_m[i].wraps ||
                act.ovf != disp_m[i].ovf) begin
                n_bad++;
                $display("FAIL %s dut%0d: got vld=%0d phase=%0d diff=%0d wraps=%0d ovf=%0d, want vld=%0d phase=%0d diff=%0d wraps=%0d ovf=%0d",
                         tag, i, act.vld, act.phase, act.diff, act.wraps, act.ovf,
                         disp_m[i].vld, disp_m[i].phase, disp_m[i].diff, disp_m[i].wraps, disp_m[i].ovf);
            end
        end
    endtask

    task automatic expect_int(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic step(input bit v, input int d, input bit c, input bit r, input string tag);
        valid = v;
        data  = d[W-1:0];
        clear = c;
        rst   = r;
        @(posedge clk);
        model_edge(v, d, c, r);
        #1;
        check_model(tag);
    endtask

    vec_t tbl[$];
    int   cur;
    int   stp;
    int   nout;

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = W'(1234);
        clear = 1'b0;

        // Reset held with a valid sample on the input: everything stays at zero.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1234, 1'b0, 1'b1, "reset_hold");
            expect_int("reset_valid", int'(valid_a), 0);
            expect_int("reset_phase", int'(phase_a), 0);
        end
        step(1'b1, 1234, 1'b0, 1'b0, "reset_release");
        expect_int("first_lat_1", int'(valid_a), 0);
        step(1'b0, 0, 1'b0, 1'b0, "reset_first");
        expect_int("first_lat_2", int'(valid_a), 1);
        expect_int("first_phase", int'(phase_a), 1234);

        // Directed vectors on the default-width instance; outputs are after each edge.
        tbl.push_back('{0, 0,     1, 0, 0,      0,     0});
        tbl.push_back('{1, 100,   0, 0, 0,      0,     0});
        tbl.push_back('{0, 0,     0, 1, 100,    0,     0});
        tbl.push_back('{0, 0,     0, 0, 100,    0,     0});
        tbl.push_back('{0, 0,     1, 0, 0,      0,     0});
        tbl.push_back('{1, 16000, 0, 0, 0,      0,     0});
        tbl.push_back('{1, 200,   0, 1, 16000,  0,     0});
        tbl.push_back('{0, 0,     0, 1, 16584,  584,   1});
        tbl.push_back('{0, 0,     1, 0, 0,      0,     0});
        tbl.push_back('{1, 200,   0, 0, 0,      0,     0});
        tbl.push_back('{1, 16300, 0, 1, 200,    0,     0});
        tbl.push_back('{0, 0,     0, 1, -84,    -284,  -1});
        tbl.push_back('{0, 0,     1, 0, 0,      0,     0});
        tbl.push_back('{1, 0,     0, 0, 0,      0,     0});
        tbl.push_back('{1, 8192,  0, 1, 0,      0,     0});
        tbl.push_back('{0, 0,     0, 1, -8192,  -8192, -1});
        tbl.push_back('{0, 0,     1, 0, 0,      0,     0});
        tbl.push_back('{1, 8192,  0, 0, 0,      0,     0});
        tbl.push_back('{1, 0,     0, 1, 8192,   0,     0});
        tbl.push_back('{0, 0,     0, 1, 0,      -8192, 0});
        tbl.push_back('{0, 0,     0, 0, 0,      -8192, 0});
        tbl.push_back('{1, 5000,  1, 0, 0,      0,     0});
        tbl.push_back('{0, 0,     0, 0, 0,      0,     0});
        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].d, tbl[k].c, 1'b0, "table");
            n_vec++;
            if (valid_a != tbl[k].e_vld || int'(phase_a) != tbl[k].e_phase ||
                int'(diff_a) != tbl[k].e_diff || int'(wraps_a) != tbl[k].e_wraps || ovf_a != 1'b0) begin
                n_bad++;
                $display("FAIL table row %0d: got vld=%0d phase=%0d diff=%0d wraps=%0d ovf=%0d, want vld=%0d phase=%0d diff=%0d wraps=%0d ovf=0",
                         k, valid_a, int'(phase_a), int'(diff_a), int'(wraps_a), ovf_a,
                         tbl[k].e_vld, tbl[k].e_phase, tbl[k].e_diff, tbl[k].e_wraps);
            end
        end

        // Saturation on the 2-bit counter: ramp of 4096 wraps every 4th sample.
        step(1'b0, 0, 1'b1, 1'b0, "sat_clear");
        nout = 0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) step(1'b1, (k * 4096) % M, 1'b0, 1'b0, "sat_ramp");
            else        step(1'b0, 0, 1'b0, 1'b0, "sat_flush");
            if (valid_b) begin
                expect_int("sat_diff", int'(diff_b), (nout == 0) ? 0 : 4096);
                expect_int("sat_wraps", int'(wraps_b), (nout >= 4) ? 1 : 0);
                expect_int("sat_ovf", int'(ovf_b), (nout >= 8) ? 1 : 0);
                nout++;
            end
        end
        expect_int("sat_count", nout, 16);

        // Clear wins over a same-cycle sample; valid_o stays low for two cycles.
        step(1'b1, 1000, 1'b1, 1'b0, "clr_valid");
        expect_int("clr_vld_1", int'(valid_b), 0);
        expect_int("clr_ovf", int'(ovf_b), 0);
        expect_int("clr_wraps", int'(wraps_b), 0);
        step(1'b1, 3000, 1'b0, 1'b0, "clr_next");
        expect_int("clr_vld_2", int'(valid_b), 0);
        step(1'b0, 0, 1'b0, 1'b0, "clr_out");
        expect_int("clr_vld_3", int'(valid_b), 1);
        expect_int("clr_phase", int'(phase_b), 3000);
        expect_int("clr_diff", int'(diff_b), 0);

        // Randomised drift segments with jitter, gaps, rare clears and rare resets.
        cur = 0;
        stp = 0;
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit c;
            bit r;
            if (n % 300 == 0) begin
                case ($urandom_range(0, 5))
                    0: stp = 1000;
                    1: stp = -1000;
                    2: stp = 5000;
                    3: stp = -5000;
                    4: stp = H;
                    default: stp = int'($urandom_range(0, M - 1)) - H;
                endcase
            end
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 399) == 0);
            r = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 15) == 0) cur = int'($urandom_range(0, M - 1));
            else cur = (((cur + stp + int'($urandom_range(0, 64)) - 32) % M) + M) % M;
            step(v, cur, c, r, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
